// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int UART_CLKS_PER_BIT    = 434;
    localparam int UART_BYTES_PER_BLOCK = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - UART byte receiver: synchronizer, bit FSM, byte and error strobes
// UART_RX_PARITY_EN adds an even-parity bit after the data bits; otherwise 8N1.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       CLK_50MHZ,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic           rx_s1, rx_s2, rx_d;
    logic           rx_fall;
    uart_rx_state_t state_q, state_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic [2:0]     bit_q, bit_n;
    logic [7:0]     shift_q, shift_n;
`ifdef UART_RX_PARITY_EN
    logic           par_bad_q, par_bad_n;
`endif

    // rx_d lags the synchronizer output by one cycle so the start edge is seen on clean data
    always_ff @(posedge CLK_50MHZ) begin
        if (!reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_d      <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_d      <= rx_s2;
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_q     <= bit_n;
            shift_q   <= shift_n;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_n;
`endif
        end
    end

    assign rx_fall   = rx_d & ~rx_s2;
    assign busy      = (state_q != ST_IDLE);
    assign byte_data = shift_q;

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q + CW'(1);
        bit_n      = bit_q;
        shift_n    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad_q;
        parity_err = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (rx_fall) state_n = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s2, shift_q[7:1]};
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = rx_s2 ^ (^shift_q);
                    state_n   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    // a bad stop bit outranks a parity mismatch
                    if (!rx_s2) frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) parity_err = 1'b1;
`endif
                    else byte_valid = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/uart_recv64.sv
// rtl/uart_recv64.sv - UART receiver assembling BYTES_PER_BLOCK bytes into a 64-bit word
module uart_recv64
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = UART_CLKS_PER_BIT,
    parameter int BYTES_PER_BLOCK = UART_BYTES_PER_BLOCK
) (
    input  logic        CLK_50MHZ,
    input  logic        reset,
    input  logic        rx,
    output logic [63:0] data_out,
    output logic        valid,
    output logic        busy,
    output logic        frame_err,
    output logic        parity_err
);

    localparam int BCW = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(BYTES_PER_BLOCK - 1);

    logic [7:0]     rx_byte;
    logic           byte_valid, byte_frame_err, byte_parity_err;
    logic [BCW-1:0] byte_cnt_q;
    logic [63:0]    asm_q, asm_shifted;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .CLK_50MHZ (CLK_50MHZ),
        .reset     (reset),
        .rx        (rx),
        .byte_data (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (byte_frame_err),
        .parity_err(byte_parity_err),
        .busy      (busy)
    );

    // first byte of a block ends up in the top byte of data_out
    assign asm_shifted = (asm_q << 8) | {56'd0, rx_byte};

    always_ff @(posedge CLK_50MHZ) begin
        if (!reset) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_err  <= byte_frame_err;
            parity_err <= byte_parity_err;
            if (byte_valid) begin
                if (byte_cnt_q == BYTE_LAST) begin
                    data_out   <= asm_shifted;
                    valid      <= 1'b1;
                    byte_cnt_q <= '0;
                    asm_q      <= '0;
                end else begin
                    asm_q      <= asm_shifted;
                    byte_cnt_q <= byte_cnt_q + BCW'(1);
                end
            end else if (byte_frame_err || byte_parity_err) begin
                byte_cnt_q <= '0;
                asm_q      <= '0;
            end
        end
    end

endmodule
